xif_offload_ctrl: RTL and testbench

- Core-side initiator for the X-IF coprocessor offload protocol; drives the issue/commit channels toward the vector accelerator and consumes its result channel.
- Accepts one offload request per handshake from the core decode stage, tracks in-flight instructions in an in-order scoreboard FIFO, and turns accelerator results into register-file writes.
- Sits between the scalar core pipeline and the accelerator's issue/commit/result ports.

---
 rtl/xif_offload_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_xif_offload_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_offload_ctrl.sv
// Core-side X-IF offload initiator: issues one instruction at a time, commits it,
// and tracks accepted writeback instructions in an in-order scoreboard.
module xif_offload_ctrl #(
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,

   input  logic                offload_valid_i,
   output logic                offload_ready_o,
   input  logic [31:0]         offload_instr_i,
   input  logic [31:0]         offload_rs1_i,
   input  logic [31:0]         offload_rs2_i,
   output logic                offload_resp_valid_o,
   output logic                offload_accept_o,
   output logic                offload_writeback_o,

   output logic                issue_valid_o,
   input  logic                issue_ready_i,
   output logic [31:0]         issue_instr_o,
   output logic [31:0]         issue_rs0_o,
   output logic [31:0]         issue_rs1_o,
   output logic [ID_WIDTH-1:0] issue_id_o,
   input  logic                issue_accept_i,
   input  logic                issue_writeback_i,

   output logic                commit_valid_o,
   output logic [ID_WIDTH-1:0] commit_id_o,
   output logic                commit_kill_o,

   input  logic                result_valid_i,
   output logic                result_ready_o,
   input  logic [ID_WIDTH-1:0] result_id_i,
   input  logic [31:0]         result_data_i,
   input  logic                result_we_i,

   output logic                rf_we_o,
   output logic [4:0]          rf_waddr_o,
   output logic [31:0]         rf_wdata_o,

   output logic                busy_o,
   output logic                err_o
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      COMMIT
   } state_t;

   state_t              state_q, state_d;

   logic [31:0]         instr_q;
   logic [31:0]         rs1_q;
   logic [31:0]         rs2_q;
   logic [ID_WIDTH-1:0] id_q;
   logic [ID_WIDTH-1:0] next_id_q;
   logic                accept_q;

   logic [ID_WIDTH-1:0] sb_id_q [MAX_OUTSTANDING];
   logic [4:0]          sb_rd_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [CNT_W-1:0]    count_q;

   logic                rf_we_q;
   logic [4:0]          rf_waddr_q;
   logic [31:0]         rf_wdata_q;
   logic                err_q;

   logic                req_hs;
   logic                issue_hs;
   logic                sb_push;
   logic                sb_pop;
   logic                result_hs;
   logic                head_match;
   logic                rf_write;
   logic [ID_WIDTH-1:0] head_id;
   logic [4:0]          head_rd;

   // Ready is held low during reset so every output reads 0 while rst_i is high.
   assign offload_ready_o = ~rst_i && (state_q == IDLE) && (count_q < CNT_MAX);
   assign result_ready_o  = ~rst_i;

   assign req_hs    = offload_valid_i && offload_ready_o;
   assign issue_hs  = (state_q == ISSUE) && issue_ready_i;
   assign sb_push   = issue_hs && issue_accept_i && issue_writeback_i;
   assign result_hs = result_valid_i && result_ready_o;

   assign head_id    = sb_id_q[rd_ptr_q];
   assign head_rd    = sb_rd_q[rd_ptr_q];
   assign head_match = (count_q != '0) && (result_id_i == head_id);
   assign sb_pop     = result_hs && head_match;
   assign rf_write   = sb_pop && result_we_i && (head_rd != 5'd0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_hs)        state_d = ISSUE;
         ISSUE:   if (issue_ready_i) state_d = COMMIT;
         COMMIT:                     state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request capture and id allocation; fields stay frozen until the issue handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instr_q   <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         id_q      <= '0;
         next_id_q <= '0;
         accept_q  <= 1'b0;
      end else begin
         if (req_hs) begin
            instr_q <= offload_instr_i;
            rs1_q   <= offload_rs1_i;
            rs2_q   <= offload_rs2_i;
            id_q    <= next_id_q;
         end
         if (issue_hs) begin
            accept_q  <= issue_accept_i;
            next_id_q <= next_id_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (sb_push) begin
         sb_id_q[wr_ptr_q] <= id_q;
         sb_rd_q[wr_ptr_q] <= instr_q[11:7];
      end
   end

   // A push and pop in the same cycle leave the occupancy unchanged.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (sb_push) begin
            wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         end
         if (sb_pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         end
         case ({sb_push, sb_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         rf_we_q <= rf_write;
         if (rf_write) begin
            rf_waddr_q <= head_rd;
            rf_wdata_q <= result_data_i;
         end
         if (result_hs && !head_match) begin
            err_q <= 1'b1;
         end
      end
   end

   assign offload_resp_valid_o = issue_hs;
   assign offload_accept_o     = issue_hs && issue_accept_i;
   assign offload_writeback_o  = issue_hs && issue_writeback_i;

   assign issue_valid_o = (state_q == ISSUE);
   assign issue_instr_o = instr_q;
   assign issue_rs0_o   = rs1_q;
   assign issue_rs1_o   = rs2_q;
   assign issue_id_o    = id_q;

   assign commit_valid_o = (state_q == COMMIT);
   assign commit_id_o    = id_q;
   assign commit_kill_o  = (state_q == COMMIT) && !accept_q;

   assign rf_we_o    = rf_we_q;
   assign rf_waddr_o = rf_waddr_q;
   assign rf_wdata_o = rf_wdata_q;

   assign busy_o = (state_q != IDLE) || (count_q != '0);
   assign err_o  = err_q;

endmodule

// File: tb/tb_xif_offload_ctrl.sv
// Scoreboard bench for xif_offload_ctrl: drivers push expected responses,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_xif_offload_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        offload_valid_i = 1'b0;
   logic        offload_ready_o;
   logic [31:0] offload_instr_i = '0;
   logic [31:0] offload_rs1_i = '0;
   logic [31:0] offload_rs2_i = '0;
   logic        offload_resp_valid_o;
   logic        offload_accept_o;
   logic        offload_writeback_o;
   logic        issue_valid_o;
   logic        issue_ready_i = 1'b0;
   logic [31:0] issue_instr_o;
   logic [31:0] issue_rs0_o;
   logic [31:0] issue_rs1_o;
   logic [3:0]  issue_id_o;
   logic        issue_accept_i = 1'b0;
   logic        issue_writeback_i = 1'b0;
   logic        commit_valid_o;
   logic [3:0]  commit_id_o;
   logic        commit_kill_o;
   logic        result_valid_i = 1'b0;
   logic        result_ready_o;
   logic [3:0]  result_id_i = '0;
   logic [31:0] result_data_i = '0;
   logic        result_we_i = 1'b0;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        busy_o;
   logic        err_o;

   xif_offload_ctrl #(.ID_WIDTH(4), .MAX_OUTSTANDING(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .offload_valid_i(offload_valid_i), .offload_ready_o(offload_ready_o),
      .offload_instr_i(offload_instr_i), .offload_rs1_i(offload_rs1_i),
      .offload_rs2_i(offload_rs2_i), .offload_resp_valid_o(offload_resp_valid_o),
      .offload_accept_o(offload_accept_o), .offload_writeback_o(offload_writeback_o),
      .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
      .issue_instr_o(issue_instr_o), .issue_rs0_o(issue_rs0_o),
      .issue_rs1_o(issue_rs1_o), .issue_id_o(issue_id_o),
      .issue_accept_i(issue_accept_i), .issue_writeback_i(issue_writeback_i),
      .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o),
      .commit_kill_o(commit_kill_o),
      .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
      .result_id_i(result_id_i), .result_data_i(result_data_i),
      .result_we_i(result_we_i),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [3:0] id; logic [31:0] instr, rs1, rs2; } issue_t;
   typedef struct { logic acc, wb; } resp_t;
   typedef struct { logic [3:0] id; logic kill; } commit_t;
   typedef struct { logic [4:0] addr; logic [31:0] data; } rf_t;
   typedef struct { logic [3:0] id; logic [4:0] rd; } sb_t;

   issue_t  exp_issue[$];
   resp_t   exp_resp[$];
   commit_t exp_commit[$];
   rf_t     exp_rf[$];
   sb_t     model[$];

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [3:0] exp_next_id = '0;
   logic       exp_err = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mkInstr(input logic [4:0] rd, input logic [19:0] hi);
      return {hi, rd, 7'h5B};
   endfunction

   // Monitor: samples 1 time unit after each negedge, where drivers have settled.
   initial begin
      issue_t  ei;
      resp_t   er;
      commit_t ec;
      rf_t     ef;
      forever begin
         @(negedge clk_i);
         #1;
         if (issue_valid_o && issue_ready_i) begin
            if (exp_issue.size() == 0) checkOutput("issue_unexpected", 32'(issue_id_o), 32'hFFFF_FFFF);
            else begin
               ei = exp_issue.pop_front();
               checkOutput("issue_id", 32'(issue_id_o), 32'(ei.id));
               checkOutput("issue_instr", issue_instr_o, ei.instr);
               checkOutput("issue_rs0", issue_rs0_o, ei.rs1);
               checkOutput("issue_rs1", issue_rs1_o, ei.rs2);
            end
         end
         if (offload_resp_valid_o) begin
            if (exp_resp.size() == 0) checkOutput("resp_unexpected", 32'd1, 32'd0);
            else begin
               er = exp_resp.pop_front();
               checkOutput("resp_accept", 32'(offload_accept_o), 32'(er.acc));
               checkOutput("resp_writeback", 32'(offload_writeback_o), 32'(er.wb));
            end
         end
         if (commit_valid_o) begin
            if (exp_commit.size() == 0) checkOutput("commit_unexpected", 32'(commit_id_o), 32'hFFFF_FFFF);
            else begin
               ec = exp_commit.pop_front();
               checkOutput("commit_id", 32'(commit_id_o), 32'(ec.id));
               checkOutput("commit_kill", 32'(commit_kill_o), 32'(ec.kill));
            end
         end
         if (rf_we_o) begin
            if (exp_rf.size() == 0) checkOutput("rf_unexpected", 32'(rf_waddr_o), 32'hFFFF_FFFF);
            else begin
               ef = exp_rf.pop_front();
               checkOutput("rf_waddr", 32'(rf_waddr_o), 32'(ef.addr));
               checkOutput("rf_wdata", rf_wdata_o, ef.data);
            end
         end
      end
   end

   task automatic doReset();
      @(negedge clk_i);
      rst_i = 1'b1;
      offload_valid_i = 1'b0; issue_ready_i = 1'b0; result_valid_i = 1'b0;
      exp_issue.delete(); exp_resp.delete(); exp_commit.delete(); exp_rf.delete(); model.delete();
      @(negedge clk_i);
      checkOutput("rst_offload_ready", 32'(offload_ready_o), 32'd0);
      checkOutput("rst_issue_valid", 32'(issue_valid_o), 32'd0);
      checkOutput("rst_issue_id", 32'(issue_id_o), 32'd0);
      checkOutput("rst_commit_valid", 32'(commit_valid_o), 32'd0);
      checkOutput("rst_rf_we", 32'(rf_we_o), 32'd0);
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      checkOutput("rst_err", 32'(err_o), 32'd0);
      checkOutput("rst_result_ready", 32'(result_ready_o), 32'd0);
      exp_next_id = '0;
      exp_err = 1'b0;
      rst_i = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                                input int stall, input logic acc, input logic wb);
      int waited = 0;
      @(negedge clk_i);
      while (!offload_ready_o && waited < 100) begin
         @(negedge clk_i);
         waited++;
      end
      if (!offload_ready_o) begin
         n_cmp++; n_bad++;
         $display("[TB] FAIL ready_timeout: offload_ready_o still 0 after %0d cycles", waited);
         return;
      end
      offload_valid_i = 1'b1;
      offload_instr_i = instr; offload_rs1_i = rs1; offload_rs2_i = rs2;
      @(negedge clk_i);
      offload_valid_i = 1'b0;
      offload_instr_i = '0; offload_rs1_i = '0; offload_rs2_i = '0;
      for (int i = 0; i < stall; i++) begin
         checkOutput("stall_issue_valid", 32'(issue_valid_o), 32'd1);
         checkOutput("stall_issue_instr", issue_instr_o, instr);
         checkOutput("stall_issue_id", 32'(issue_id_o), 32'(exp_next_id));
         @(negedge clk_i);
      end
      checkOutput("issue_valid", 32'(issue_valid_o), 32'd1);
      exp_issue.push_back('{id: exp_next_id, instr: instr, rs1: rs1, rs2: rs2});
      exp_resp.push_back('{acc: acc, wb: wb});
      exp_commit.push_back('{id: exp_next_id, kill: !acc});
      if (acc && wb) model.push_back('{id: exp_next_id, rd: instr[11:7]});
      issue_ready_i = 1'b1; issue_accept_i = acc; issue_writeback_i = wb;
      @(negedge clk_i);
      issue_ready_i = 1'b0; issue_accept_i = 1'b0; issue_writeback_i = 1'b0;
      exp_next_id = exp_next_id + 4'd1;
   endtask

   task automatic sendResult(input logic [3:0] id, input logic [31:0] data, input logic we);
      sb_t m;
      @(negedge clk_i);
      result_valid_i = 1'b1; result_id_i = id; result_data_i = data; result_we_i = we;
      if (model.size() != 0 && model[0].id == id) begin
         m = model.pop_front();
         if (we && m.rd != 5'd0) exp_rf.push_back('{addr: m.rd, data: data});
      end else begin
         exp_err = 1'b1;
      end
      @(negedge clk_i);
      result_valid_i = 1'b0; result_we_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      doReset();
      @(negedge clk_i);
      checkOutput("idle_offload_ready", 32'(offload_ready_o), 32'd1);
      checkOutput("idle_result_ready", 32'(result_ready_o), 32'd1);

      // Single accept+writeback, stalled issue, then its result.
      applyStimulus(mkInstr(5'd5, 20'h12345), 32'h1111_0001, 32'h2222_0002, 2, 1'b1, 1'b1);
      sendResult(4'd0, 32'hDEAD_BEEF, 1'b1);
      @(negedge clk_i);
      checkOutput("single_busy_after", 32'(busy_o), 32'd0);

      // Rejected instruction: kill commit, nothing tracked.
      applyStimulus(mkInstr(5'd6, 20'h0BAD0), 32'h3, 32'h4, 0, 1'b0, 1'b0);
      checkOutput("reject_busy_commit", 32'(busy_o), 32'd1);
      @(negedge clk_i);
      checkOutput("reject_busy_after", 32'(busy_o), 32'd0);

      // Fill the scoreboard with ids 2..5.
      for (int i = 0; i < 4; i++)
         applyStimulus(mkInstr(5'(i + 1), 20'(i)), 32'(i), 32'(i * 2), i % 2, 1'b1, 1'b1);
      @(negedge clk_i);
      checkOutput("full_offload_ready", 32'(offload_ready_o), 32'd0);
      sendResult(4'd2, 32'hA000_0002, 1'b1);
      checkOutput("full_ready_after_pop", 32'(offload_ready_o), 32'd1);
      sendResult(4'd3, 32'hA000_0003, 1'b1);
      sendResult(4'd4, 32'hA000_0004, 1'b0);
      sendResult(4'd5, 32'hA000_0005, 1'b1);
      @(negedge clk_i);
      checkOutput("drain_busy", 32'(busy_o), 32'd0);
      checkOutput("no_err_yet", 32'(err_o), 32'(exp_err));

      // Protocol errors: empty scoreboard, then id mismatch.
      sendResult(4'd7, 32'h5555_5555, 1'b1);
      @(negedge clk_i);
      checkOutput("err_empty", 32'(err_o), 32'd1);
      applyStimulus(mkInstr(5'd7, 20'h77777), 32'h7, 32'h8, 0, 1'b1, 1'b1);
      sendResult(4'd9, 32'h6666_6666, 1'b1);
      sendResult(4'd6, 32'h7777_7777, 1'b1);
      @(negedge clk_i);
      checkOutput("err_sticky", 32'(err_o), 32'(exp_err));
      checkOutput("err_busy", 32'(busy_o), 32'd0);

      // Reset clears err; then 17 answered instructions wrap the id.
      doReset();
      for (int i = 0; i < 17; i++) begin
         applyStimulus(mkInstr(5'(i % 8), 20'(i + 32'h100)), 32'(i), 32'(~i), i % 3, 1'b1, 1'b1);
         sendResult(4'(i), 32'h1000_0000 + 32'(i) * 32'h111, (i != 3));
      end
      checkOutput("wrap_next_id", 32'(exp_next_id), 32'd1);
      checkOutput("wrap_err", 32'(err_o), 32'd0);

      // Reset while ISSUE is pending: no commit must follow, id restarts at 0.
      @(negedge clk_i);
      offload_valid_i = 1'b1;
      offload_instr_i = mkInstr(5'd9, 20'h99999);
      @(negedge clk_i);
      offload_valid_i = 1'b0;
      checkOutput("midrst_issue_valid", 32'(issue_valid_o), 32'd1);
      doReset();
      @(negedge clk_i);
      checkOutput("midrst_issue_after", 32'(issue_valid_o), 32'd0);
      applyStimulus(mkInstr(5'd10, 20'hCAFE0), 32'hC, 32'hD, 1, 1'b1, 1'b1);
      sendResult(4'd0, 32'h0BAD_F00D, 1'b1);

      repeat (3) @(negedge clk_i);
      checkOutput("left_issue", 32'(exp_issue.size()), 32'd0);
      checkOutput("left_resp", 32'(exp_resp.size()), 32'd0);
      checkOutput("left_commit", 32'(exp_commit.size()), 32'd0);
      checkOutput("left_rf", 32'(exp_rf.size()), 32'd0);
      checkOutput("final_busy", 32'(busy_o), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
